// File: rtl/deco_id.sv
// deco_id: port-ID decoder for the soft-processor I/O bus.
// Turns an 8-bit port ID into one registered peripheral-select strobe (RTC, VGA,
// keyboard, sound) plus the register address inside that peripheral. Unmapped IDs
// produce no select and a zero address, identical to the reset state.
module deco_id (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] id_port,
   output logic       actRTC,
   output logic       actVGA,
   output logic       actTeclado,
   output logic       actsonido,
   output logic [7:0] dir
);

   // Combinational decode results, registered below.
   logic       w_sel_rtc;
   logic       w_sel_vga;
   logic       w_sel_tec;
   logic       w_sel_son;
   logic [7:0] w_dir;

   // Registered outputs.
   logic       r_act_rtc;
   logic       r_act_vga;
   logic       r_act_tec;
   logic       r_act_son;
   logic [7:0] r_dir;

   // Decode the port ID into a one-hot select and a peripheral-local address.
   always_comb begin
      w_sel_rtc = 1'b0;
      w_sel_vga = 1'b0;
      w_sel_tec = 1'b0;
      w_sel_son = 1'b0;
      w_dir     = 8'h00;
      if (id_port[7:4] == 4'h0) begin
         // RTC registers are scattered, so map each ID individually.
         w_sel_rtc = 1'b1;
         case (id_port[3:0])
            4'h0:    w_dir = 8'h21;
            4'h1:    w_dir = 8'h22;
            4'h2:    w_dir = 8'h23;
            4'h3:    w_dir = 8'h24;
            4'h4:    w_dir = 8'h25;
            4'h5:    w_dir = 8'h26;
            4'h6:    w_dir = 8'h41;
            4'h7:    w_dir = 8'h42;
            4'h8:    w_dir = 8'h43;
            4'h9:    w_dir = 8'h02;
            4'hA:    w_dir = 8'hF0;
            default: begin
               // 0x0B..0x0F are holes in the RTC window.
               w_sel_rtc = 1'b0;
               w_dir     = 8'h00;
            end
         endcase
      end else if (id_port[7:4] == 4'h1) begin
         w_sel_vga = 1'b1;
         w_dir     = {4'h0, id_port[3:0]};
      end else if (id_port[7:3] == 5'b00100) begin
         w_sel_tec = 1'b1;
         w_dir     = {5'b0, id_port[2:0]};
      end else if (id_port[7:3] == 5'b00101) begin
         w_sel_son = 1'b1;
         w_dir     = {5'b0, id_port[2:0]};
      end
   end

   // Register the decode; synchronous reset overrides it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_act_rtc <= 1'b0;
         r_act_vga <= 1'b0;
         r_act_tec <= 1'b0;
         r_act_son <= 1'b0;
         r_dir     <= 8'h00;
      end else begin
         r_act_rtc <= w_sel_rtc;
         r_act_vga <= w_sel_vga;
         r_act_tec <= w_sel_tec;
         r_act_son <= w_sel_son;
         r_dir     <= w_dir;
      end
   end

   assign actRTC     = r_act_rtc;
   assign actVGA     = r_act_vga;
   assign actTeclado = r_act_tec;
   assign actsonido  = r_act_son;
   assign dir        = r_dir;

endmodule

// File: tb/tb_deco_id.sv
// tb_deco_id: directed self-checking bench for the deco_id port-ID decoder.
module tb_deco_id;

   logic       clk;
   logic       reset;
   logic [7:0] id_port;
   logic       actRTC;
   logic       actVGA;
   logic       actTeclado;
   logic       actsonido;
   logic [7:0] dir;

   int unsigned n_checks;
   int unsigned n_fails;

   localparam logic [7:0] RtcDir [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                            8'h41, 8'h42, 8'h43, 8'h02, 8'hF0};

   deco_id u_dut (
      .clk        (clk),
      .reset      (reset),
      .id_port    (id_port),
      .actRTC     (actRTC),
      .actVGA     (actVGA),
      .actTeclado (actTeclado),
      .actsonido  (actsonido),
      .dir        (dir)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value; packed as {rtc,vga,tec,son,dir} for decode checks.
   task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
      end
   endtask

   // Reference map built from the address table, range by range.
   function automatic logic [11:0] model(input logic [7:0] id);
      logic [11:0] r;
      r = 12'h000;
      if (id <= 8'h0A)                      r = {4'b1000, RtcDir[id]};
      else if (id >= 8'h10 && id <= 8'h1F)  r = {4'b0100, id - 8'h10};
      else if (id >= 8'h20 && id <= 8'h27)  r = {4'b0010, id - 8'h20};
      else if (id >= 8'h28 && id <= 8'h2F)  r = {4'b0001, id - 8'h28};
      return r;
   endfunction

   function automatic logic [11:0] observed();
      return {actRTC, actVGA, actTeclado, actsonido, dir};
   endfunction

   // Present one ID, clock it in, check the registered decode just after the edge.
   task automatic step(input logic [7:0] id, input string tag);
      id_port = id;
      @(posedge clk);
      #1;
      check_eq(tag, observed(), model(id));
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset    = 1'b1;
      id_port  = 8'h10;

      // Reset held two edges with a valid VGA ID present.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_eq("reset", observed(), 12'h000);
      end
      reset = 1'b0;
      step(8'h10, "post_reset_vga");
      check_eq("post_reset_vga_lit", observed(), 12'h400);

      // Hand-computed corner vectors.
      step(8'h00, "rtc_00");
      check_eq("rtc_00_lit", observed(), 12'h821);
      step(8'h05, "rtc_05");
      check_eq("rtc_05_lit", observed(), 12'h826);
      step(8'h0A, "rtc_0a");
      check_eq("rtc_0a_lit", observed(), 12'h8F0);
      step(8'h0B, "none_0b");
      check_eq("none_0b_lit", observed(), 12'h000);
      step(8'h0F, "none_0f");
      step(8'h1F, "vga_1f");
      check_eq("vga_1f_lit", observed(), 12'h40F);
      step(8'h20, "tec_20");
      check_eq("tec_20_lit", observed(), 12'h200);
      step(8'h27, "tec_27");
      check_eq("tec_27_lit", observed(), 12'h207);
      step(8'h28, "son_28");
      check_eq("son_28_lit", observed(), 12'h100);
      step(8'h2F, "son_2f");
      check_eq("son_2f_lit", observed(), 12'h107);
      step(8'h30, "none_30");
      check_eq("none_30_lit", observed(), 12'h000);
      step(8'hFF, "none_ff");
      step(8'h80, "none_80");
      step(8'h09, "rtc_09");
      check_eq("rtc_09_lit", observed(), 12'h802);

      // Back-to-back sweep, with one-hot check on every row.
      for (int i = 0; i < 128; i++) begin
         step(8'(i), $sformatf("sweep_%02h", i));
         check_eq($sformatf("onehot_%02h", i),
                  12'({31'd0, $onehot0({actRTC, actVGA, actTeclado, actsonido})}), 12'h001);
      end

      // Reset asserted mid-sequence while 0x03 is on the bus.
      step(8'h02, "pre_mid_reset");
      id_port = 8'h03;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_reset", observed(), 12'h000);
      reset = 1'b0;
      step(8'h03, "resume_rtc_03");
      check_eq("resume_rtc_03_lit", observed(), 12'h824);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
